regbank_sb: RTL and testbench

REGBANK_SB -- requirements
Module: regbank_sb

---
 rtl/regbank_sb.sv | 95 +++++++++
 tb/tb_regbank_sb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_sb.sv
// Register bank with per-register pending (scoreboard) bits for in-order issue.
// Reservations mark a producer in flight; the retiring write clears the mark.
module regbank_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_dr,
  output logic              busy1,
  output logic              busy2,
  output logic              rsv_err,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              all_idle
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic              wr_en;
  logic              rsv_en;
  logic              rsv_err_nxt;
  logic              fwd1, fwd2;
  logic              zr1, zr2;

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Register 0 is hardwired when ZERO_R0 is set, so writes and reservations to it vanish.
  assign wr_en  = write && !(ZERO_R0 && (dr == '0));
  assign rsv_en = rsv && !(ZERO_R0 && (rsv_dr == '0));

  // Clear first, then set: a same-cycle write+rsv to one register leaves it pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_en) begin
      pend_nxt[dr] = 1'b0;
    end
    if (rsv_en) begin
      pend_nxt[rsv_dr] = 1'b1;
    end
  end

  assign rsv_err_nxt = rsv_en && pend[rsv_dr] && !(wr_en && (dr == rsv_dr));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      pend     <= '0;
      rsv_err  <= 1'b0;
      pend_cnt <= '0;
    end else begin
      if (wr_en) begin
        regs[dr] <= wrData;
      end
      pend     <= pend_nxt;
      rsv_err  <= rsv_err_nxt;
      pend_cnt <= popcount(pend_nxt);
    end
  end

  assign all_idle = (pend_cnt == '0);

  // Forwarding is suppressed while in reset so the read ports settle to zero.
  assign fwd1 = BYPASS && reset && wr_en && (dr == sr1);
  assign fwd2 = BYPASS && reset && wr_en && (dr == sr2);
  assign zr1  = ZERO_R0 && (sr1 == '0);
  assign zr2  = ZERO_R0 && (sr2 == '0);

  assign rdData1 = zr1 ? '0 : (fwd1 ? wrData : regs[sr1]);
  assign rdData2 = zr2 ? '0 : (fwd2 ? wrData : regs[sr2]);
  assign busy1   = pend[sr1] && !fwd1 && !zr1;
  assign busy2   = pend[sr2] && !fwd2 && !zr2;

endmodule

// File: tb/tb_regbank_sb.sv
// Scoreboard bench for regbank_sb: expectations queued at drive time, checked at negedge.
module tb_regbank_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic              clk;
  logic              reset;
  logic              write;
  logic [ADDR_W-1:0] dr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] sr1, sr2;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_dr;

  logic [DATA_W-1:0] rdData1, rdData2;
  logic              busy1, busy2, rsv_err, all_idle;
  logic [ADDR_W:0]   pend_cnt;

  logic [DATA_W-1:0] z_rdData1, z_rdData2;
  logic              z_busy1, z_busy2, z_rsv_err, z_all_idle;
  logic [ADDR_W:0]   z_pend_cnt;

  regbank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .write(write), .dr(dr), .wrData(wrData),
    .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
    .rsv(rsv), .rsv_dr(rsv_dr), .busy1(busy1), .busy2(busy2),
    .rsv_err(rsv_err), .pend_cnt(pend_cnt), .all_idle(all_idle)
  );

  regbank_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1), .BYPASS(1'b1)) dutz (
    .clk(clk), .reset(reset), .write(write), .dr(dr), .wrData(wrData),
    .sr1(sr1), .sr2(sr2), .rdData1(z_rdData1), .rdData2(z_rdData2),
    .rsv(rsv), .rsv_dr(rsv_dr), .busy1(z_busy1), .busy2(z_busy2),
    .rsv_err(z_rsv_err), .pend_cnt(z_pend_cnt), .all_idle(z_all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  // reference state for the ZERO_R0=0 instance
  logic [DATA_W-1:0] mreg [NREG];
  logic              mpend [NREG];
  logic              merr;
  int                mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:  return 32'(rdData1);
      1:  return 32'(rdData2);
      2:  return 32'(busy1);
      3:  return 32'(busy2);
      4:  return 32'(rsv_err);
      5:  return 32'(pend_cnt);
      6:  return 32'(all_idle);
      7:  return 32'(z_rdData1);
      8:  return 32'(z_rdData2);
      9:  return 32'(z_busy1);
      10: return 32'(z_busy2);
      11: return 32'(z_rsv_err);
      12: return 32'(z_pend_cnt);
      default: return 32'(z_all_idle);
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.tag, observe(mon_e.sel), mon_e.exp);
    end
  end

  function automatic void push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endfunction

  function automatic void push_all(input string tag);
    logic f1, f2;
    f1 = reset && write && (dr == sr1);
    f2 = reset && write && (dr == sr2);
    push({tag, ".rd1"},  0, 32'(f1 ? wrData : mreg[sr1]));
    push({tag, ".rd2"},  1, 32'(f2 ? wrData : mreg[sr2]));
    push({tag, ".bsy1"}, 2, 32'(mpend[sr1] && !f1));
    push({tag, ".bsy2"}, 3, 32'(mpend[sr2] && !f2));
    push({tag, ".err"},  4, 32'(merr));
    push({tag, ".cnt"},  5, 32'(mcnt));
    push({tag, ".idle"}, 6, 32'(mcnt == 0));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
    merr = 1'b0;
    mcnt = 0;
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      model_clear();
      return;
    end
    merr = rsv && mpend[rsv_dr] && !(write && (dr == rsv_dr));
    if (write) begin
      mreg[dr]  = wrData;
      mpend[dr] = 1'b0;
    end
    if (rsv) mpend[rsv_dr] = 1'b1;
    mcnt = 0;
    for (int i = 0; i < NREG; i++) mcnt += int'(mpend[i]);
  endfunction

  task automatic drive(input logic w, input logic [2:0] d, input logic [15:0] data,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic r, input logic [2:0] rd);
    write = w; dr = d; wrData = data; sr1 = s1; sr2 = s2; rsv = r; rsv_dr = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag, input logic w, input logic [2:0] d,
                      input logic [15:0] data, input logic [2:0] s1, input logic [2:0] s2,
                      input logic r, input logic [2:0] rd);
    drive(w, d, data, s1, s2, r, rd);
    push_all(tag);
    tick();
  endtask

  task automatic do_reset(input string tag, input logic w, input logic [2:0] d,
                          input logic [15:0] data, input logic r, input logic [2:0] rd);
    reset = 1'b0;
    drive(w, d, data, 3'd1, 3'd2, r, rd);
    tick();
    write = 1'b0;
    rsv   = 1'b0;
    push_all(tag);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    model_clear();
    #1;
    do_reset("rst0", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

    // write k*10, then read pairs
    for (int k = 0; k < NREG; k++) step("wr", 1'b1, 3'(k), 16'(k * 10), 3'd7, 3'd6, 1'b0, 3'd0);
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(2 * p), 3'(2 * p + 1), 1'b0, 3'd0);
      push("pair.lo", 0, 32'(p * 20));
      push("pair.hi", 1, 32'(p * 20 + 10));
      push_all("pair");
      tick();
    end

    // reserve 3, then retire it with bypass
    step("rsv3", 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b1, 3'd3);
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0, 3'd0);
    push("rsv3.busy", 2, 32'd1);
    push("rsv3.cnt", 5, 32'd1);
    push_all("rsv3.chk");
    tick();
    drive(1'b1, 3'd3, 16'h1234, 3'd3, 3'd1, 1'b0, 3'd0);
    push("byp3.rd", 0, 32'h1234);
    push("byp3.busy", 2, 32'd0);
    push_all("byp3");
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 3'd0);
    push("ret3.cnt", 5, 32'd0);
    push("ret3.idle", 6, 32'd1);
    push_all("ret3");
    tick();

    // double reservation of 5
    step("rsv5a", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b1, 3'd5);
    step("rsv5b", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b1, 3'd5);
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd4, 1'b0, 3'd0);
    push("err5.err", 4, 32'd1);
    push("err5.cnt", 5, 32'd1);
    push_all("err5");
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd4, 1'b0, 3'd0);
    push("err5.drop", 4, 32'd0);
    push_all("err5b");
    tick();
    step("clr5", 1'b1, 3'd5, 16'h0055, 3'd5, 3'd0, 1'b0, 3'd0);

    // same-cycle retire and re-reserve of 2
    step("rsv2", 1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b1, 3'd2);
    step("wr2rsv2", 1'b1, 3'd2, 16'h00AA, 3'd2, 3'd0, 1'b1, 3'd2);
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0, 3'd0);
    push("r2.rd", 0, 32'h00AA);
    push("r2.busy", 2, 32'd1);
    push("r2.err", 4, 32'd0);
    push("r2.cnt", 5, 32'd1);
    push_all("r2");
    tick();
    step("clr2", 1'b1, 3'd2, 16'h0022, 3'd2, 3'd3, 1'b0, 3'd0);

    // hardwired register 0 on the ZERO_R0 instance
    drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0);
    push("z0.rd1", 7, 32'd0);
    push("z0.rd2", 8, 32'd0);
    push("z0.busy1", 9, 32'd0);
    push_all("z0.main");
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    push("z0n.rd1", 7, 32'd0);
    push("z0n.busy1", 9, 32'd0);
    push("z0n.busy2", 10, 32'd0);
    push("z0n.err", 11, 32'd0);
    push("z0n.cnt", 12, 32'd0);
    push("z0n.idle", 13, 32'd1);
    push_all("z0n.main");
    tick();
    step("clr0", 1'b1, 3'd0, 16'h0000, 3'd0, 3'd1, 1'b0, 3'd0);

    // random mix against the reference state
    for (int i = 0; i < 60; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    for (int k = 0; k < NREG; k++) step("drain", 1'b1, 3'(k), 16'(k + 16'h100), 3'(k), 3'd0, 1'b0, 3'd0);

    // fill every pending bit, then reset during a write
    for (int k = 0; k < NREG; k++) step("fill", 1'b0, 3'd0, 16'h0, 3'(k), 3'd0, 1'b1, 3'(k));
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b0, 3'd0);
    push("full.cnt", 5, 32'd8);
    push("full.idle", 6, 32'd0);
    push_all("full");
    tick();
    do_reset("rst1", 1'b1, 3'd4, 16'h5555, 1'b1, 3'd4);
    for (int p = 0; p < 4; p++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(2 * p), 3'(2 * p + 1), 1'b0, 3'd0);
      push("post.lo", 0, 32'd0);
      push("post.hi", 1, 32'd0);
      push("post.cnt", 5, 32'd0);
      push("post.idle", 6, 32'd1);
      push_all("post");
      tick();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
